accumulator: RTL



---
 rtl/accumulator_pkg.sv | 27 ++
 rtl/accumulator_sat_adder.sv | 26 ++
 rtl/accumulator.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/accumulator_pkg.sv
// Shared types and helpers for the accumulator: FSM state encoding and
// counter sizing used by the top and its adder.
package accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        STALL = 1'b1
    } acc_state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // A single-product block still needs a one-bit counter.
    function automatic int cnt_width(input int acc_length);
        return (clog2(acc_length) < 1) ? 1 : clog2(acc_length);
    endfunction

endpackage

// File: rtl/accumulator_sat_adder.sv
// WIDTH-bit unsigned adder; with SATURATE set the result clamps at all-ones.
// o_carry reports that the true sum did not fit in WIDTH bits.
module sat_adder #(
    parameter int WIDTH    = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    logic [WIDTH:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b};
    assign o_carry = w_full[WIDTH];

    generate
        if (SATURATE) begin : g_sat
            assign o_sum = w_full[WIDTH] ? {WIDTH{1'b1}} : w_full[WIDTH-1:0];
        end else begin : g_wrap
            assign o_sum = w_full[WIDTH-1:0];
        end
    endgenerate

endmodule

// File: rtl/accumulator.sv
// Integrate-and-dump of ACC_LENGTH unsigned products with a valid/ready output.
// Define ACCUMULATOR_SATURATE_EN for clamping sums and a per-block overflow flag.
module accumulator
    import accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_LENGTH = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  clear_i,
    output logic [ACC_WIDTH-1:0]  data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  overflow_o
);

    localparam int                   CNT_WIDTH = cnt_width(ACC_LENGTH);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(ACC_LENGTH - 1);
`ifdef ACCUMULATOR_SATURATE_EN
    localparam bit                   SAT_EN    = 1'b1;
`else
    localparam bit                   SAT_EN    = 1'b0;
`endif

    acc_state_e           r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_data;
    logic                 r_valid;

    logic                 w_accept;
    logic                 w_xfer;
    logic                 w_first;
    logic                 w_last;
    logic [ACC_WIDTH-1:0] w_addend;
    logic [ACC_WIDTH-1:0] w_ext;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_carry;

    acc_state_e           w_state_n;
    logic [CNT_WIDTH-1:0] w_cnt_n;
    logic [ACC_WIDTH-1:0] w_acc_n;
    logic [ACC_WIDTH-1:0] w_data_n;
    logic                 w_valid_n;

    // Valid/ready: a product moves on an edge with valid_i && ready_o, a sum
    // moves on an edge with valid_o && ready_i; ready_o depends on state only.
    assign ready_o  = (r_state == ACCUM);
    assign data_o   = r_data;
    assign valid_o  = r_valid;

    assign w_accept = valid_i && (r_state == ACCUM);
    assign w_xfer   = r_valid && ready_i;
    assign w_first  = (r_cnt == '0);
    assign w_last   = (r_cnt == LAST_CNT);
    assign w_addend = w_first ? '0 : r_acc;
    assign w_ext    = ACC_WIDTH'(data_i);

    sat_adder #(
        .WIDTH    (ACC_WIDTH),
        .SATURATE (SAT_EN)
    ) u_add (
        .i_a     (w_addend),
        .i_b     (w_ext),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    always_comb begin
        w_cnt_n   = r_cnt;
        w_acc_n   = r_acc;
        w_data_n  = r_data;
        w_valid_n = r_valid && !w_xfer;
        if (clear_i) begin
            w_cnt_n = '0;
            w_acc_n = '0;
        end else if (w_accept) begin
            if (w_last) begin
                w_cnt_n   = '0;
                w_data_n  = w_sum;
                w_valid_n = 1'b1;
            end else begin
                w_cnt_n = r_cnt + CNT_WIDTH'(1);
                w_acc_n = w_sum;
            end
        end
        // Stall only when the block's closing product would have nowhere to go.
        w_state_n = (w_valid_n && (w_cnt_n == LAST_CNT)) ? STALL : ACCUM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_acc   <= w_acc_n;
            r_data  <= w_data_n;
            r_valid <= w_valid_n;
        end
    end

`ifdef ACCUMULATOR_SATURATE_EN
    logic r_sticky;
    logic r_ovf;
    logic w_sticky_blk;

    assign w_sticky_blk = r_sticky | w_carry;
    assign overflow_o   = r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (clear_i) begin
            r_sticky <= 1'b0;
        end else if (w_accept) begin
            if (w_last) begin
                r_ovf    <= w_sticky_blk;
                r_sticky <= 1'b0;
            end else begin
                r_sticky <= w_sticky_blk;
            end
        end
    end
`else
    logic w_unused_carry;

    assign w_unused_carry = w_carry;
    assign overflow_o     = 1'b0;
`endif

endmodule
